// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit engine: one-hot FSM encodings and
// a counter-width helper.
package uart_pkg;

  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_START  = 5'b00010;
  localparam logic [4:0] S_DATA   = 5'b00100;
  localparam logic [4:0] S_PARITY = 5'b01000;
  localparam logic [4:0] S_STOP   = 5'b10000;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic Clock,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge Clock) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_xmt_engine.sv
// UART transmitter: one-deep holding register feeding a shift register,
// sequenced by a one-hot FSM that advances on baud ticks.
module uart_xmt_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  Clock,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  Serial_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = cnt_w(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  logic [4:0]            state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  par_q, par_d;
  logic                  serial_q, serial_d;
  logic                  tick, restart, load, accept;

  // Holding the divider at zero while idle makes every frame start on a fresh bit period.
  assign restart = (state_q == S_IDLE);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .Clock  (Clock),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    accept      = data_valid & ~hold_full_q;

    case (state_q)
      S_IDLE:  load = hold_full_q;
      S_START: if (tick) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (tick) begin
        shift_d = shift_q >> 1;
        if (bit_q == LAST_DATA) begin
          bit_d   = '0;
          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_PARITY: if (tick) begin
        state_d = S_STOP;
        bit_d   = '0;
      end
      S_STOP: if (tick) begin
        if (bit_q == LAST_STOP) begin
          bit_d   = '0;
          state_d = S_IDLE;
          load    = hold_full_q;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A load only happens with the holding register full, so it never collides with an accept.
    if (load) begin
      state_d     = S_START;
      bit_d       = '0;
      shift_d     = hold_q;
      par_d       = (^hold_q) ^ PAR_ODD;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    serial_d = 1'b1;
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = par_d;
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_q       <= '0;
      hold_full_q <= 1'b0;
      serial_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      hold_full_q <= hold_full_d;
      serial_q    <= serial_d;
    end
  end

  always_ff @(posedge Clock) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
    par_q   <= par_d;
  end

  assign data_ready = ~hold_full_q;
  assign busy       = (state_q != S_IDLE);
  assign tx_done    = (state_q == S_STOP) && (bit_q == LAST_STOP) && tick;
  assign Serial_out = serial_q;

endmodule
